// File: rtl/imm_extend_pipe_pkg.sv
// Shared types and helpers for the registered immediate-extension stage.
package imm_pkg;

    // Widest immediate and tag any configuration of the stage can carry.
    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 64;

    // Immediate format selector driven by the decoder.
    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_Z   = 3'b101,
        IMM_SH  = 3'b110,
        IMM_RSV = 3'b111
    } imm_src_t;

    // One buffered result at maximum width: immediate, sideband tag, reserved-format flag.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        logic [TAG_MAX_W-1:0] tag;
        logic                 illegal;
    } imm_entry_t;

    // Widen a 32-bit immediate to 64 bits by replicating its top bit.
    function automatic logic [63:0] sext64(input logic [31:0] value);
        return {{32{value[31]}}, value};
    endfunction

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// Combinational RV32I/RV64I immediate decoder: instruction + format -> extended immediate.
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instruction,
    input  logic [2:0]            immSrc,
    output logic [DATA_WIDTH-1:0] imm,
    output logic                  illegal
);

    logic [31:0] raw32;

    // Build the 32-bit sign-extended form of the selected format; reserved formats give zero.
    always_comb begin
        raw32   = '0;
        illegal = 1'b0;
        case (imm_src_t'(immSrc))
            IMM_I:   raw32 = {{20{instruction[31]}}, instruction[31:20]};
            IMM_S:   raw32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            IMM_B:   raw32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                              instruction[30:25], instruction[11:8], 1'b0};
            IMM_J:   raw32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                              instruction[20], instruction[30:21], 1'b0};
            IMM_U:   raw32 = {instruction[31:12], 12'b0};
            IMM_Z:   raw32 = {27'b0, instruction[19:15]};
            IMM_SH:  raw32 = (DATA_WIDTH == 64) ? {26'b0, instruction[25:20]}
                                                : {27'b0, instruction[24:20]};
            IMM_RSV: illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // Zero-extended formats have bit 31 clear, so the same widening serves every format.
    generate
        if (DATA_WIDTH == 64) begin : g_wide
            assign imm = sext64(raw32);
        end else begin : g_narrow
            assign imm = raw32;
        end
    endgenerate

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a 2-entry skid FIFO and valid/ready on both sides.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic [2:0]             immSrc,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  immExt,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   illegal,
    output logic [1:0]             occupancy
);

    // Entry layout sized to this instance rather than the package's maximum-width form.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  illegal;
    } entry_t;

    logic [DATA_WIDTH-1:0] decImm;
    logic                  decIllegal;
    entry_t                newEntry;
    entry_t                slot0;
    entry_t                slot1;
    logic                  accept;
    logic                  pop;
    logic [1:0]            occNext;

    imm_decode #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_decode (
        .instruction(instruction),
        .immSrc     (immSrc),
        .imm        (decImm),
        .illegal    (decIllegal)
    );

    assign newEntry = '{imm: decImm, tag: in_tag, illegal: decIllegal};
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    // Next occupancy: accept and pop in the same cycle cancel out.
    always_comb begin
        occNext = occupancy;
        case ({accept, pop})
            2'b10:   occNext = occupancy + 2'd1;
            2'b01:   occNext = occupancy - 2'd1;
            default: occNext = occupancy;
        endcase
    end

    // Occupancy and both handshake flags are registered so neither side sees a combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            occupancy <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            occupancy <= occNext;
            in_ready  <= (occNext != 2'd2);
            out_valid <= (occNext != 2'd0);
        end
    end

    // Slot 0 is always the head; a pop shifts slot 1 forward, and new entries fill the first free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
        end else if (!flush) begin
            if (pop && accept) begin
                slot0 <= newEntry;
            end else if (pop) begin
                slot0 <= slot1;
            end else if (accept) begin
                if (occupancy == 2'd0) begin
                    slot0 <= newEntry;
                end else begin
                    slot1 <= newEntry;
                end
            end
        end
    end

    assign immExt  = slot0.imm;
    assign out_tag = slot0.tag;
    assign illegal = slot0.illegal;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: one 32-bit and one 64-bit instance share stimulus and a queue-based model.
module tb_imm_extend_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instruction = '0;
    logic [2:0]  immSrc = '0;
    logic [31:0] in_tag = '0;

    logic        inReady32, outValid32, illegal32;
    logic [31:0] immExt32, outTag32;
    logic [1:0]  occ32;
    logic        inReady64, outValid64, illegal64;
    logic [63:0] immExt64;
    logic [31:0] outTag64;
    logic [1:0]  occ64;

    int asserts = 0;
    int failures = 0;

    typedef struct {
        imm_entry_t  e;
        logic [31:0] imm32;
    } exp_t;

    exp_t modelQ[$];
    bit   modelReady = 1'b1;

    imm_extend_pipe #(.INSTR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(inReady32),
        .instruction(instruction), .immSrc(immSrc), .in_tag(in_tag), .out_valid(outValid32),
        .out_ready(out_ready), .immExt(immExt32), .out_tag(outTag32), .illegal(illegal32),
        .occupancy(occ32)
    );

    imm_extend_pipe #(.INSTR_WIDTH(32), .DATA_WIDTH(64), .TAG_WIDTH(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(inReady64),
        .instruction(instruction), .immSrc(immSrc), .in_tag(in_tag), .out_valid(outValid64),
        .out_ready(out_ready), .immExt(immExt64), .out_tag(outTag64), .illegal(illegal64),
        .occupancy(occ64)
    );

    always #5 clk = ~clk;

    // Reference immediate as a signed field value scaled by its implicit shift.
    function automatic logic [63:0] refImm(input logic [31:0] instr, input logic [2:0] src, input bit wide);
        longint             v;
        logic signed [11:0] f12;
        logic signed [19:0] f20;
        v = 0;
        case (src)
            3'd0: begin f12 = instr[31:20]; v = f12; end
            3'd1: begin f12 = {instr[31:25], instr[11:7]}; v = f12; end
            3'd2: begin f12 = {instr[31], instr[7], instr[30:25], instr[11:8]}; v = longint'(f12) * 2; end
            3'd3: begin f20 = {instr[31], instr[19:12], instr[20], instr[30:21]}; v = longint'(f20) * 2; end
            3'd4: begin f20 = instr[31:12]; v = longint'(f20) * 4096; end
            3'd5: v = longint'(instr[19:15]);
            3'd6: v = wide ? longint'(instr[25:20]) : longint'(instr[24:20]);
            default: v = 0;
        endcase
        if (!wide) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    function automatic exp_t makeExp(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] tag);
        exp_t        x;
        logic [63:0] narrow;
        narrow      = refImm(instr, src, 1'b0);
        x.e.imm     = refImm(instr, src, 1'b1);
        x.e.tag     = {32'b0, tag};
        x.e.illegal = (src == 3'd7);
        x.imm32     = narrow[31:0];
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the buffer: an ordered queue of at most two entries with a registered ready.
    always @(posedge clk or negedge rst_n) begin
        bit acc, pp;
        if (!rst_n || flush) begin
            modelQ.delete();
            modelReady = 1'b1;
        end else begin
            pp  = (modelQ.size() > 0) && out_ready;
            acc = in_valid && modelReady;
            if (pp) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(makeExp(instruction, immSrc, in_tag));
            modelReady = (modelQ.size() < 2);
        end
    end

    // Compare both instances against the model every falling edge.
    always @(negedge clk) begin
        checkOutput("occ32", {62'b0, occ32}, 64'(modelQ.size()));
        checkOutput("occ64", {62'b0, occ64}, 64'(modelQ.size()));
        checkOutput("out_valid32", {63'b0, outValid32}, {63'b0, modelQ.size() > 0});
        checkOutput("out_valid64", {63'b0, outValid64}, {63'b0, modelQ.size() > 0});
        checkOutput("in_ready32", {63'b0, inReady32}, {63'b0, modelReady});
        checkOutput("in_ready64", {63'b0, inReady64}, {63'b0, modelReady});
        if (modelQ.size() > 0) begin
            checkOutput("imm32", {32'b0, immExt32}, {32'b0, modelQ[0].imm32});
            checkOutput("imm64", immExt64, modelQ[0].e.imm);
            checkOutput("tag32", {32'b0, outTag32}, modelQ[0].e.tag);
            checkOutput("tag64", {32'b0, outTag64}, modelQ[0].e.tag);
            checkOutput("illegal32", {63'b0, illegal32}, {63'b0, modelQ[0].e.illegal});
            checkOutput("illegal64", {63'b0, illegal64}, {63'b0, modelQ[0].e.illegal});
        end
    end

    // Offer one instruction and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] tag);
        int n;
        @(negedge clk);
        #2;
        in_valid    = 1'b1;
        instruction = instr;
        immSrc      = src;
        in_tag      = tag;
        n = 0;
        while (!inReady32 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        asserts++;
        if (!inReady32) begin
            failures++;
            $display("[TB] FAIL handshake_timeout: in_ready stayed 0, required 1 (tag 0x%0h)", tag);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
    endtask

    logic [31:0] bjsInstr [3] = '{32'hFE000EE3, 32'hFF9FF06F, 32'hFE20AE23};
    logic [2:0]  bjsSrc   [3] = '{3'd2, 3'd3, 3'd1};
    logic [31:0] bjsImm   [3] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC};

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset_imm", {32'b0, immExt32}, 64'h0);
        checkOutput("reset_tag", {32'b0, outTag32}, 64'h0);
        checkOutput("reset_illegal", {63'b0, illegal32}, 64'h0);
        checkOutput("reset_in_ready", {63'b0, inReady32}, 64'h1);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // I-format with one-cycle latency.
        applyStimulus(32'hFFF00093, 3'd0, 32'h0);
        checkOutput("lit_I_imm32", {32'b0, immExt32}, 64'hFFFFFFFF);
        checkOutput("lit_I_valid", {63'b0, outValid32}, 64'h1);
        checkOutput("lit_I_illegal", {63'b0, illegal32}, 64'h0);

        // B, J, S back to back with tags 1..3.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(bjsInstr[i], bjsSrc[i], 32'(i + 1));
            checkOutput("lit_BJS_imm32", {32'b0, immExt32}, {32'b0, bjsImm[i]});
            checkOutput("lit_BJS_tag", {32'b0, outTag32}, 64'(i + 1));
        end

        // U and SH on the 64-bit instance.
        applyStimulus(32'h80000037, 3'd4, 32'h4);
        checkOutput("lit_U_neg64", immExt64, 64'hFFFFFFFF80000000);
        checkOutput("lit_U_neg32", {32'b0, immExt32}, 64'h80000000);
        applyStimulus(32'h123450B7, 3'd4, 32'h5);
        checkOutput("lit_U_pos64", immExt64, 64'h0000000012345000);
        applyStimulus(32'h03F01013, 3'd6, 32'h6);
        checkOutput("lit_SH64", immExt64, 64'h3F);
        checkOutput("lit_SH32", {32'b0, immExt32}, 64'h1F);
        applyStimulus(32'h000F8073, 3'd5, 32'h7);
        checkOutput("lit_Z64", immExt64, 64'h1F);

        // Backpressure: third instruction waits for space.
        drain();
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(32'h00100093, 3'd0, 32'h10);
                applyStimulus(32'h00200093, 3'd0, 32'h11);
                applyStimulus(32'h00300093, 3'd0, 32'h12);
            end
            begin
                repeat (4) @(negedge clk);
                checkOutput("lit_bp_occ", {62'b0, occ32}, 64'h2);
                checkOutput("lit_bp_ready", {63'b0, inReady32}, 64'h0);
                checkOutput("lit_bp_head", {32'b0, outTag32}, 64'h10);
                #2;
                out_ready = 1'b1;
                @(negedge clk);
                checkOutput("lit_bp_ready_rise", {63'b0, inReady32}, 64'h1);
                checkOutput("lit_bp_next_head", {32'b0, outTag32}, 64'h11);
            end
        join

        // Flush while full with a simultaneous offer.
        drain();
        out_ready = 1'b0;
        applyStimulus(32'h00700093, 3'd0, 32'h20);
        applyStimulus(32'h00800093, 3'd0, 32'h21);
        @(negedge clk);
        #2;
        flush       = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'h00900093;
        in_tag      = 32'hBAD;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lit_flush_occ", {62'b0, occ32}, 64'h0);
        checkOutput("lit_flush_valid", {63'b0, outValid32}, 64'h0);
        checkOutput("lit_flush_ready", {63'b0, inReady32}, 64'h1);
        #2;
        out_ready = 1'b1;
        applyStimulus(32'h00500093, 3'd0, 32'h22);
        checkOutput("lit_post_flush_tag", {32'b0, outTag32}, 64'h22);
        checkOutput("lit_post_flush_imm", {32'b0, immExt32}, 64'h5);

        // Reserved format.
        applyStimulus(32'hFFFFFFFF, 3'd7, 32'h30);
        checkOutput("lit_rsv_imm32", {32'b0, immExt32}, 64'h0);
        checkOutput("lit_rsv_imm64", immExt64, 64'h0);
        checkOutput("lit_rsv_illegal", {63'b0, illegal32}, 64'h1);

        // Asynchronous reset while full.
        drain();
        out_ready = 1'b0;
        applyStimulus(32'h00A00093, 3'd0, 32'h40);
        applyStimulus(32'h00B00093, 3'd0, 32'h41);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("lit_arst_valid32", {63'b0, outValid32}, 64'h0);
        checkOutput("lit_arst_occ32", {62'b0, occ32}, 64'h0);
        checkOutput("lit_arst_valid64", {63'b0, outValid64}, 64'h0);
        checkOutput("lit_arst_occ64", {62'b0, occ64}, 64'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
